cog_divider: RTL and testbench
==============================

Name: cog_divider

Overview:
- Downstream stage of the gravity-sum block.
- On a start trigger it captures SUM_S, SUM_SX and SUM_SY.
- It computes the centre of gravity X = SUM_SX/SUM_S and Y = SUM_SY/SUM_S in fixed point, using two parallel bit-serial restoring dividers.
- It drives a BUSY level back upstream and presents registered results to the output/report stage.

Parameters:
- ADDR_WIDTH, 11, integer bits of each coordinate.
- FRAC_BITS, 4, fractional bits of each coordinate.
- SUM_S_WIDTH, 20, width of the divisor sum.
- SUM_SX_WIDTH, 28, width of the X dividend sum.
- SUM_SY_WIDTH, 28, width of the Y dividend sum; must equal SUM_SX_WIDTH.
- Derived, not overridable: DW = SUM_SX_WIDTH+FRAC_BITS (32); CW = ADDR_WIDTH+FRAC_BITS (15).

Ports:
- CCLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- iSTART_TRIG  in  1  start request level from the sum stage; only its rising edge is used.
- iSUM_S  in  SUM_S_WIDTH  sum of weights (divisor).
- iSUM_SX  in  SUM_SX_WIDTH  X-weighted sum.
- iSUM_SY  in  SUM_SY_WIDTH  Y-weighted sum.
- oBUSY  out  1  high while a division is in progress.
- oVALID  out  1  one-cycle pulse when new results are presented.
- oCOG_X  out  CW  X coordinate, unsigned fixed point (ADDR_WIDTH.FRAC_BITS).
- oCOG_Y  out  CW  Y coordinate, unsigned fixed point (ADDR_WIDTH.FRAC_BITS).
- oDIV_ZERO  out  1  last result computed with iSUM_S == 0.
- oSAT  out  1  last result saturated in X or Y.
- oSTATE  out  2  debug copy of the state register.

Behaviour:
- Reset (RST=1, asynchronous):
  - state = IDLE; all outputs 0; operand, remainder and quotient registers 0.
  - The trigger-history register resets to 1, so a trigger held high across reset release does not start an operation.
- Edge detect: start = iSTART_TRIG & ~trig_d; trig_d is registered every cycle.
- State encoding: IDLE=0, DIV=1, DONE=2. Value 3 returns to IDLE with the same effects as reset.
- IDLE:
  - On the edge where start=1, latch all three sums, set oBUSY<=1, load bit counter = DW-1, go to DIV.
  - A start in any other state is ignored; it is not queued.
- DIV, one quotient bit per cycle per divider, MSB first:
  - The dividend is the sum shifted left by FRAC_BITS (width DW). The remainder is SUM_S_WIDTH+1 bits.
  - Each cycle: rem = {rem, next dividend bit}. If rem >= divisor, subtract and set the quotient bit to 1, else 0.
  - When the counter reaches 0, go to DONE.
  - Total: exactly DW cycles in DIV.
- DONE, one cycle:
  - Register oCOG_X and oCOG_Y from the quotient.
  - If quotient > 2^CW-1, output all ones and set oSAT. oSAT = X saturated OR Y saturated.
  - If the latched divisor == 0: force both coordinates to 0, oDIV_ZERO<=1, oSAT<=0. Latency is unchanged.
  - Set oVALID<=1 and oBUSY<=0, return to IDLE.
- Timing:
  - oBUSY is high for exactly DW+1 cycles (33 at defaults), starting the cycle after the start edge.
  - oVALID rises together with the fall of oBUSY and lasts one cycle.
  - The upstream stage waits ≤511 cycles for BUSY to rise and then for it to fall; this latency fits that window.
- Output holding:
  - oCOG_X, oCOG_Y, oDIV_ZERO and oSAT hold their values until the next DONE.
  - Input sums may change while BUSY; only the latched copies are used.
- Arithmetic: results are truncated, with no rounding. All arithmetic is unsigned.
- Reset mid-operation: abort immediately, oBUSY=0, no oVALID, outputs return to 0.
- Back-to-back: a new rising edge in the cycle after DONE (IDLE) starts a new operation. A trigger level still high from the previous run does not retrigger.

Test Plan:
- Integer result: S=100, SX=32000, SY=24000, trigger edge.
  - Required: oBUSY high for 33 cycles, then oVALID pulse.
  - oCOG_X=0x1400 (320.0), oCOG_Y=0x0F00 (240.0), oDIV_ZERO=0, oSAT=0.
- Fractional truncation: S=3, SX=10, SY=0.
  - Required: oCOG_X=0x0035 (53/16=3.3125), oCOG_Y=0x0000.
- Divide by zero: S=0, SX=5, SY=7.
  - Required: same 33-cycle BUSY, oCOG_X=oCOG_Y=0, oDIV_ZERO=1, oSAT=0.
  - A following valid run clears oDIV_ZERO.
- Saturation: S=1, SX=0x7FFFFFF, SY=16.
  - Required: oCOG_X=0x7FFF, oCOG_Y=0x0100, oSAT=1.
- Trigger handling:
  - Trigger held high for 511 cycles: exactly one oVALID.
  - Second rising edge at busy cycle 10: ignored, with one result from the first operands.
  - Sums changed during BUSY: result unaffected.
- Reset mid-operation:
  - RST asserted at busy cycle 10: oBUSY=0 immediately, no oVALID, outputs 0.
  - Trigger high at reset release: no operation starts.

Source files
------------

// File: rtl/cog_divider.sv
// Centre-of-gravity divider: latches the gravity sums on a start edge and runs two
// parallel bit-serial restoring dividers to produce fixed-point X/Y coordinates.
module cog_divider #(
    parameter int ADDR_WIDTH   = 11,
    parameter int FRAC_BITS    = 4,
    parameter int SUM_S_WIDTH  = 20,
    parameter int SUM_SX_WIDTH = 28,
    parameter int SUM_SY_WIDTH = 28
) (
    input  logic                            CCLK,
    input  logic                            RST,
    input  logic                            iSTART_TRIG,
    input  logic [SUM_S_WIDTH-1:0]          iSUM_S,
    input  logic [SUM_SX_WIDTH-1:0]         iSUM_SX,
    input  logic [SUM_SY_WIDTH-1:0]         iSUM_SY,
    output logic                            oBUSY,
    output logic                            oVALID,
    output logic [ADDR_WIDTH+FRAC_BITS-1:0] oCOG_X,
    output logic [ADDR_WIDTH+FRAC_BITS-1:0] oCOG_Y,
    output logic                            oDIV_ZERO,
    output logic                            oSAT,
    output logic [1:0]                      oSTATE
);

    localparam int DW    = SUM_SX_WIDTH + FRAC_BITS;
    localparam int CW    = ADDR_WIDTH + FRAC_BITS;
    localparam int SW    = SUM_S_WIDTH;
    localparam int CNT_W = $clog2(DW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic             trig_d;
    logic             start;
    logic [SW-1:0]    dvs;
    logic [DW-1:0]    dvd_x, dvd_y;
    logic [SW:0]      rem_x, rem_y;
    logic [DW-1:0]    q_x, q_y;
    logic [CNT_W-1:0] cnt;

    logic [SW:0]      rx_sh, ry_sh, rx_nx, ry_nx;
    logic             qx_bit, qy_bit;
    logic             sat_x, sat_y;

    assign start  = iSTART_TRIG & ~trig_d;
    assign oSTATE = state;
    assign sat_x  = |q_x[DW-1:CW];
    assign sat_y  = |q_y[DW-1:CW];

    // One restoring step per divider; a set remainder MSB already means "exceeds divisor".
    always_comb begin
        rx_sh  = {rem_x[SW-1:0], dvd_x[DW-1]};
        ry_sh  = {rem_y[SW-1:0], dvd_y[DW-1]};
        qx_bit = rem_x[SW] | (rx_sh >= {1'b0, dvs});
        qy_bit = rem_y[SW] | (ry_sh >= {1'b0, dvs});
        rx_nx  = qx_bit ? rx_sh - {1'b0, dvs} : rx_sh;
        ry_nx  = qy_bit ? ry_sh - {1'b0, dvs} : ry_sh;
    end

    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:  state_nx = start ? S_DIV : S_IDLE;
            S_DIV:   state_nx = (cnt == '0) ? S_DONE : S_DIV;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            trig_d    <= 1'b1;
            dvs       <= '0;
            dvd_x     <= '0;
            dvd_y     <= '0;
            rem_x     <= '0;
            rem_y     <= '0;
            q_x       <= '0;
            q_y       <= '0;
            cnt       <= '0;
            oBUSY     <= 1'b0;
            oVALID    <= 1'b0;
            oCOG_X    <= '0;
            oCOG_Y    <= '0;
            oDIV_ZERO <= 1'b0;
            oSAT      <= 1'b0;
        end else begin
            trig_d <= iSTART_TRIG;
            oVALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvs   <= iSUM_S;
                        dvd_x <= {iSUM_SX, {FRAC_BITS{1'b0}}};
                        dvd_y <= {iSUM_SY, {FRAC_BITS{1'b0}}};
                        rem_x <= '0;
                        rem_y <= '0;
                        q_x   <= '0;
                        q_y   <= '0;
                        cnt   <= CNT_W'(DW - 1);
                        oBUSY <= 1'b1;
                    end
                end
                S_DIV: begin
                    dvd_x <= dvd_x << 1;
                    dvd_y <= dvd_y << 1;
                    rem_x <= rx_nx;
                    rem_y <= ry_nx;
                    q_x   <= {q_x[DW-2:0], qx_bit};
                    q_y   <= {q_y[DW-2:0], qy_bit};
                    cnt   <= cnt - 1'b1;
                end
                S_DONE: begin
                    if (dvs == '0) begin
                        oCOG_X    <= '0;
                        oCOG_Y    <= '0;
                        oDIV_ZERO <= 1'b1;
                        oSAT      <= 1'b0;
                    end else begin
                        oCOG_X    <= sat_x ? '1 : q_x[CW-1:0];
                        oCOG_Y    <= sat_y ? '1 : q_y[CW-1:0];
                        oDIV_ZERO <= 1'b0;
                        oSAT      <= sat_x | sat_y;
                    end
                    oVALID <= 1'b1;
                    oBUSY  <= 1'b0;
                end
                default: begin
                    dvs       <= '0;
                    dvd_x     <= '0;
                    dvd_y     <= '0;
                    rem_x     <= '0;
                    rem_y     <= '0;
                    q_x       <= '0;
                    q_y       <= '0;
                    cnt       <= '0;
                    oBUSY     <= 1'b0;
                    oCOG_X    <= '0;
                    oCOG_Y    <= '0;
                    oDIV_ZERO <= 1'b0;
                    oSAT      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cog_divider.sv
// Self-checking bench for cog_divider: directed corner cases plus randomized runs
// compared against an arithmetic model of the centre-of-gravity division.
module tb_cog_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic [19:0] sum_s;
    logic [27:0] sum_sx;
    logic [27:0] sum_sy;
    logic        busy;
    logic        valid;
    logic [14:0] cog_x;
    logic [14:0] cog_y;
    logic        div_zero;
    logic        sat;
    logic [1:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    cog_divider #(
        .ADDR_WIDTH  (11),
        .FRAC_BITS   (4),
        .SUM_S_WIDTH (20),
        .SUM_SX_WIDTH(28),
        .SUM_SY_WIDTH(28)
    ) dut (
        .CCLK       (clk),
        .RST        (rst),
        .iSTART_TRIG(trig),
        .iSUM_S     (sum_s),
        .iSUM_SX    (sum_sx),
        .iSUM_SY    (sum_sy),
        .oBUSY      (busy),
        .oVALID     (valid),
        .oCOG_X     (cog_x),
        .oCOG_Y     (cog_y),
        .oDIV_ZERO  (div_zero),
        .oSAT       (sat),
        .oSTATE     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: coordinate = floor(sum * 2^FRAC / S), clamped to 15 bits.
    function automatic void model(input logic [19:0] s, input logic [27:0] sx, input logic [27:0] sy,
                                  output logic [14:0] ex, output logic [14:0] ey,
                                  output logic edz, output logic esat);
        longint unsigned qx, qy;
        if (s == 0) begin
            ex = 0; ey = 0; edz = 1'b1; esat = 1'b0;
        end else begin
            qx = (longint'(sx) * 16) / longint'(s);
            qy = (longint'(sy) * 16) / longint'(s);
            esat = (qx > 32767) || (qy > 32767);
            ex = (qx > 32767) ? 15'h7FFF : 15'(qx);
            ey = (qy > 32767) ? 15'h7FFF : 15'(qy);
            edz = 1'b0;
        end
    endfunction

    // mode 0: trigger held; 1: re-edge and sum changes while busy; 2: trigger dropped early
    // so the next op can start in the cycle right after DONE.
    task automatic run_op(input logic [19:0] s, input logic [27:0] sx, input logic [27:0] sy,
                          input int mode, input int tail);
        logic [14:0] ex, ey;
        logic        edz, esat;
        int          busy_len, extra;
        bit          got;
        model(s, sx, sy, ex, ey, edz, esat);
        sum_s = s; sum_sx = sx; sum_sy = sy; trig = 1'b1;
        busy_len = 0; got = 0; extra = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (valid) begin
                got = 1;
                check("busy_low_at_valid", busy, 0);
            end else if (busy) begin
                busy_len++;
            end
            if (mode == 1 && c == 3) begin
                sum_s = 20'($urandom); sum_sx = 28'($urandom); sum_sy = 28'($urandom);
            end
            if (mode == 1 && c == 5) trig = 1'b0;
            if (mode == 1 && c == 10) trig = 1'b1;
            if (mode == 2 && c == 2) trig = 1'b0;
        end
        check("valid_seen", got, 1);
        check("busy_len", busy_len, 33);
        check("cog_x", cog_x, ex);
        check("cog_y", cog_y, ey);
        check("div_zero", div_zero, edz);
        check("sat", sat, esat);
        for (int c = 0; c < tail; c++) begin
            @(negedge clk);
            if (valid) extra++;
        end
        if (tail > 0) check("no_extra_valid", extra, 0);
        if (mode != 2) begin
            trig = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int vcount, bcount;
        rst = 1'b1; trig = 1'b1; sum_s = 0; sum_sx = 0; sum_sy = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_cog", {cog_x, cog_y, div_zero, sat}, 0);
        check("rst_state", state, 0);
        rst = 1'b0;
        // trigger held across reset release must not start anything
        vcount = 0; bcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) vcount++;
            if (busy)  bcount++;
        end
        check("held_trig_no_valid", vcount, 0);
        check("held_trig_no_busy", bcount, 0);
        trig = 1'b0;
        @(negedge clk);

        run_op(20'd100, 28'd32000, 28'd24000, 0, 3);
        check("int_x_const", cog_x, 15'h1400);
        check("int_y_const", cog_y, 15'h0F00);
        run_op(20'd3, 28'd10, 28'd0, 0, 3);
        check("frac_x_const", cog_x, 15'h0035);
        run_op(20'd0, 28'd5, 28'd7, 0, 3);
        run_op(20'd100, 28'd32000, 28'd24000, 0, 2);
        run_op(20'd1, 28'h7FFFFFF, 28'd16, 0, 2);
        check("sat_y_const", cog_y, 15'h0100);
        run_op(20'd7, 28'd1000, 28'd2000, 0, 480);
        run_op(20'd9, 28'd12345, 28'd54321, 1, 4);
        run_op(20'd5, 28'd77, 28'd99, 2, 0);
        run_op(20'd6, 28'd500, 28'd600, 0, 2);

        for (int i = 0; i < 24; i++) begin
            logic [19:0] s;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      s = 0;
            else if (sel < 3)  s = 20'($urandom_range(1, 15));
            else               s = 20'($urandom);
            run_op(s, 28'($urandom), 28'($urandom_range(0, 4000000)),
                   int'($urandom_range(0, 2)), int'($urandom_range(1, 5)));
        end

        // Reset in the middle of an operation, with the trigger still high at release
        run_op(20'd100, 28'd32000, 28'd24000, 0, 2);
        trig = 1'b1;
        repeat (10) @(negedge clk);
        check("busy_before_abort", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_outputs", {cog_x, cog_y, div_zero, sat, valid}, 0);
        check("abort_state", state, 0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0; bcount = 0;
        repeat (50) begin
            @(negedge clk);
            if (valid) vcount++;
            if (busy)  bcount++;
        end
        check("abort_no_valid", vcount, 0);
        check("abort_no_restart", bcount, 0);
        trig = 1'b0;
        @(negedge clk);
        run_op(20'd3, 28'd10, 28'd0, 0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
